exercise2_66_tester: RTL and testbench

Self-checking exhaustive stimulus driver for the 5-input, 2-output combinational function block (inputs x1..x5, outputs f and g). It is the driving and reading end of that block's interface. On a start pulse it walks all 32 input combinations, samples f and g after a programmable settle time, and compares them against expected truth tables. It reports pass/fail, an error count and the first failing vector. It sits between the function block and the lab board's switches and LEDs, or the bench.

---
 rtl/exercise2_66_tester.sv | 116 +++++++++++
 tb/tb_exercise2_66_tester.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/exercise2_66_tester.sv
// Exhaustive stimulus driver and checker for a 5-input, 2-output combinational block.
// Walks all 32 vectors, holds each SETTLE cycles, and compares f/g against truth tables.
module exercise2_66_tester #(
    parameter logic [31:0] F_TABLE = 32'hC8F5_0035,
    parameter logic [31:0] G_TABLE = 32'hC8F5_0035,
    parameter int unsigned SETTLE  = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_f,
    input  logic       i_g,
    output logic       o_x1,
    output logic       o_x2,
    output logic       o_x3,
    output logic       o_x4,
    output logic       o_x5,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [5:0] o_err_count,
    output logic       o_fail_seen,
    output logic [4:0] o_first_fail_idx,
    output logic [1:0] o_first_fail_fg
);

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    state_t     r_state;
    logic [4:0] r_idx;
    logic [7:0] r_settle;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [5:0] r_err;
    logic       r_fail_seen;
    logic [4:0] r_ff_idx;
    logic [1:0] r_ff_fg;

    logic       w_sample;
    logic       w_mismatch;
    logic [5:0] w_err_next;

    assign w_sample   = (r_settle == SETTLE_LAST);
    assign w_mismatch = (i_f != F_TABLE[r_idx]) || (i_g != G_TABLE[r_idx]);
    assign w_err_next = r_err + 6'(w_mismatch);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_idx       <= 5'd0;
            r_settle    <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= 6'd0;
            r_fail_seen <= 1'b0;
            r_ff_idx    <= 5'd0;
            r_ff_fg     <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state     <= S_APPLY;
                        r_idx       <= 5'd0;
                        r_settle    <= 8'd0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err       <= 6'd0;
                        r_fail_seen <= 1'b0;
                        r_ff_idx    <= 5'd0;
                        r_ff_fg     <= 2'b00;
                    end
                end
                S_APPLY: begin
                    if (w_sample) begin
                        if (w_mismatch) begin
                            r_err <= w_err_next;
                            // Only the first failure of a sweep is captured.
                            if (!r_fail_seen) begin
                                r_fail_seen <= 1'b1;
                                r_ff_idx    <= r_idx;
                                r_ff_fg     <= {i_f, i_g};
                            end
                        end
                        if (r_idx == 5'd31) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == 6'd0);
                        end else begin
                            r_idx    <= r_idx + 5'd1;
                            r_settle <= 8'd0;
                        end
                    end else begin
                        r_settle <= r_settle + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign {o_x1, o_x2, o_x3, o_x4, o_x5} = r_idx;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pass           = r_pass;
    assign o_err_count      = r_err;
    assign o_fail_seen      = r_fail_seen;
    assign o_first_fail_idx = r_ff_idx;
    assign o_first_fail_fg  = r_ff_fg;

endmodule

// File: tb/tb_exercise2_66_tester.sv
// Directed bench for exercise2_66_tester: two instances (SETTLE=1 and SETTLE=3) driving
// a behavioural function block with selectable injected faults.
module tb_exercise2_66_tester;

    localparam logic [31:0] F_TAB = 32'hC8F5_0035;
    localparam logic [31:0] G_TAB = 32'hC8F5_0035;

    logic clk;
    int   n_pass;
    int   n_total;

    // mode: 0 correct, 1 f inverted at idx 18, 2 g stuck-at-0, 3 f and g inverted everywhere
    int   a_mode;
    int   b_mode;

    logic       a_rst, a_start, a_f, a_g;
    logic       a_x1, a_x2, a_x3, a_x4, a_x5;
    logic       a_busy, a_done, a_pass, a_fail_seen;
    logic [5:0] a_err;
    logic [4:0] a_ffi;
    logic [1:0] a_fffg;
    logic [4:0] a_xv;

    logic       b_rst, b_start, b_f, b_g;
    logic       b_x1, b_x2, b_x3, b_x4, b_x5;
    logic       b_busy, b_done, b_pass, b_fail_seen;
    logic [5:0] b_err;
    logic [4:0] b_ffi;
    logic [1:0] b_fffg;
    logic [4:0] b_xv;

    assign a_xv = {a_x1, a_x2, a_x3, a_x4, a_x5};
    assign b_xv = {b_x1, b_x2, b_x3, b_x4, b_x5};

    assign a_f = F_TAB[a_xv] ^ ((a_mode == 1) && (a_xv == 5'd18)) ^ (a_mode == 3);
    assign a_g = (a_mode == 2) ? 1'b0 : (G_TAB[a_xv] ^ (a_mode == 3));
    assign b_f = F_TAB[b_xv] ^ ((b_mode == 1) && (b_xv == 5'd18)) ^ (b_mode == 3);
    assign b_g = (b_mode == 2) ? 1'b0 : (G_TAB[b_xv] ^ (b_mode == 3));

    exercise2_66_tester #(.F_TABLE(F_TAB), .G_TABLE(G_TAB), .SETTLE(1)) dut_a (
        .i_clk(clk), .i_rst(a_rst), .i_start(a_start), .i_f(a_f), .i_g(a_g),
        .o_x1(a_x1), .o_x2(a_x2), .o_x3(a_x3), .o_x4(a_x4), .o_x5(a_x5),
        .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass), .o_err_count(a_err),
        .o_fail_seen(a_fail_seen), .o_first_fail_idx(a_ffi), .o_first_fail_fg(a_fffg)
    );

    exercise2_66_tester #(.F_TABLE(F_TAB), .G_TABLE(G_TAB), .SETTLE(3)) dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_start(b_start), .i_f(b_f), .i_g(b_g),
        .o_x1(b_x1), .o_x2(b_x2), .o_x3(b_x3), .o_x4(b_x4), .o_x5(b_x5),
        .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass), .o_err_count(b_err),
        .o_fail_seen(b_fail_seen), .o_first_fail_idx(b_ffi), .o_first_fail_fg(b_fffg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_a;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    // Counts edges from the start edge (inclusive) until done is seen, bounded.
    task automatic wait_done_a(output int n);
        n = 1;
        while (!a_done && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        a_rst = 1'b1; b_rst = 1'b1;
        a_start = 1'b1; b_start = 1'b1;
        tick(); tick();
        n_total++; if ({a_xv, a_busy, a_done, a_pass} !== 8'd0) $display("FAIL reset_a_ctl got=%b want=0", {a_xv, a_busy, a_done, a_pass}); else n_pass++;
        n_total++; if ({a_err, a_fail_seen, a_ffi, a_fffg} !== 14'd0) $display("FAIL reset_a_res got=%b want=0", {a_err, a_fail_seen, a_ffi, a_fffg}); else n_pass++;
        n_total++; if ({b_xv, b_busy, b_done, b_pass, b_err, b_fail_seen, b_ffi, b_fffg} !== 22'd0) $display("FAIL reset_b got=%b want=0", {b_xv, b_busy, b_done, b_pass, b_err, b_fail_seen, b_ffi, b_fffg}); else n_pass++;
        a_start = 1'b0; b_start = 1'b0;
        a_rst = 1'b0; b_rst = 1'b0;
        tick();
        n_total++; if ({a_busy, a_done} !== 2'b00) $display("FAIL idle_a got=%b want=00", {a_busy, a_done}); else n_pass++;
    endtask

    task automatic test_clean_sweep;
        a_mode = 0;
        start_a();
        for (int k = 0; k < 32; k++) begin
            n_total++; if ({a_busy, a_done, a_xv} !== {2'b10, 5'(k)}) $display("FAIL clean_step%0d got=%b want=%b", k, {a_busy, a_done, a_xv}, {2'b10, 5'(k)}); else n_pass++;
            tick();
        end
        n_total++; if ({a_busy, a_done, a_pass} !== 3'b011) $display("FAIL clean_done got=%b want=011", {a_busy, a_done, a_pass}); else n_pass++;
        n_total++; if ({a_err, a_fail_seen, a_ffi, a_fffg} !== 14'd0) $display("FAIL clean_res got=%b want=0", {a_err, a_fail_seen, a_ffi, a_fffg}); else n_pass++;
        n_total++; if (a_xv !== 5'd31) $display("FAIL clean_xhold got=%0d want=31", a_xv); else n_pass++;
        tick(); tick();
        n_total++; if ({a_done, a_pass, a_xv} !== {2'b11, 5'd31}) $display("FAIL clean_hold got=%b want=1111111", {a_done, a_pass, a_xv}); else n_pass++;
    endtask

    task automatic test_single_fault;
        int n;
        a_mode = 1;
        start_a();
        n_total++; if ({a_done, a_pass} !== 2'b00) $display("FAIL single_restart got=%b want=00", {a_done, a_pass}); else n_pass++;
        wait_done_a(n);
        n_total++; if (n !== 33) $display("FAIL single_latency got=%0d want=33", n); else n_pass++;
        n_total++; if (a_err !== 6'd1) $display("FAIL single_err got=%0d want=1", a_err); else n_pass++;
        n_total++; if (a_ffi !== 5'd18) $display("FAIL single_idx got=%0d want=18", a_ffi); else n_pass++;
        n_total++; if (a_fffg !== 2'b01) $display("FAIL single_fg got=%b want=01", a_fffg); else n_pass++;
        n_total++; if ({a_pass, a_fail_seen} !== 2'b01) $display("FAIL single_flags got=%b want=01", {a_pass, a_fail_seen}); else n_pass++;
    endtask

    task automatic test_g_stuck;
        int n;
        a_mode = 2;
        start_a();
        wait_done_a(n);
        n_total++; if (n !== 33) $display("FAIL gstuck_latency got=%0d want=33", n); else n_pass++;
        n_total++; if (a_err !== 6'd13) $display("FAIL gstuck_err got=%0d want=13", a_err); else n_pass++;
        n_total++; if ({a_ffi, a_fffg} !== {5'd0, 2'b10}) $display("FAIL gstuck_capture got=%b want=0000010", {a_ffi, a_fffg}); else n_pass++;
        n_total++; if ({a_pass, a_fail_seen} !== 2'b01) $display("FAIL gstuck_flags got=%b want=01", {a_pass, a_fail_seen}); else n_pass++;
    endtask

    task automatic test_all_inverted;
        int n;
        logic [1:0] fg0;
        fg0 = {~F_TAB[0], ~G_TAB[0]};
        a_mode = 3;
        start_a();
        wait_done_a(n);
        n_total++; if (a_err !== 6'd32) $display("FAIL allinv_err got=%0d want=32", a_err); else n_pass++;
        n_total++; if ({a_ffi, a_fffg} !== {5'd0, fg0}) $display("FAIL allinv_capture got=%b want=%b", {a_ffi, a_fffg}, {5'd0, fg0}); else n_pass++;
        n_total++; if ({a_done, a_pass, a_fail_seen} !== 3'b101) $display("FAIL allinv_flags got=%b want=101", {a_done, a_pass, a_fail_seen}); else n_pass++;
    endtask

    task automatic test_settle3;
        int bad;
        b_mode = 1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        bad = 0;
        for (int c = 1; c <= 96; c++) begin
            if ({b_busy, b_done, b_xv} !== {2'b10, 5'((c - 1) / 3)}) begin
                if (bad == 0) $display("FAIL settle3_step c=%0d got=%b want=%b", c, {b_busy, b_done, b_xv}, {2'b10, 5'((c - 1) / 3)});
                bad++;
            end
            if (c == 31) b_start = 1'b1;
            tick();
            b_start = 1'b0;
        end
        n_total++; if (bad !== 0) $display("FAIL settle3_steps got=%0d bad want=0", bad); else n_pass++;
        n_total++; if ({b_busy, b_done} !== 2'b01) $display("FAIL settle3_done97 got=%b want=01", {b_busy, b_done}); else n_pass++;
        n_total++; if ({b_err, b_ffi, b_fffg, b_pass} !== {6'd1, 5'd18, 2'b01, 1'b0}) $display("FAIL settle3_res got=%b want=%b", {b_err, b_ffi, b_fffg, b_pass}, {6'd1, 5'd18, 2'b01, 1'b0}); else n_pass++;
        b_mode = 0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n_total++; if ({b_busy, b_done, b_err, b_fail_seen, b_ffi, b_fffg, b_xv} !== {2'b10, 19'd0}) $display("FAIL settle3_rerun_clear got=%b want=%b", {b_busy, b_done, b_err, b_fail_seen, b_ffi, b_fffg, b_xv}, {2'b10, 19'd0}); else n_pass++;
        repeat (96) tick();
        n_total++; if ({b_done, b_pass, b_err} !== {2'b11, 6'd0}) $display("FAIL settle3_rerun_done got=%b want=11000000", {b_done, b_pass, b_err}); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int n;
        a_mode = 3;
        start_a();
        repeat (7) tick();
        n_total++; if ({a_busy, a_xv, a_err} !== {1'b1, 5'd7, 6'd7}) $display("FAIL mid_pre got=%b want=%b", {a_busy, a_xv, a_err}, {1'b1, 5'd7, 6'd7}); else n_pass++;
        a_rst = 1'b1;
        a_start = 1'b1;
        tick();
        a_rst = 1'b0;
        a_start = 1'b0;
        n_total++; if ({a_xv, a_busy, a_done, a_pass, a_err, a_fail_seen, a_ffi, a_fffg} !== 22'd0) $display("FAIL mid_reset got=%b want=0", {a_xv, a_busy, a_done, a_pass, a_err, a_fail_seen, a_ffi, a_fffg}); else n_pass++;
        tick();
        n_total++; if ({a_busy, a_done} !== 2'b00) $display("FAIL mid_idle got=%b want=00", {a_busy, a_done}); else n_pass++;
        a_mode = 0;
        start_a();
        n_total++; if ({a_busy, a_xv} !== {1'b1, 5'd0}) $display("FAIL mid_restart got=%b want=100000", {a_busy, a_xv}); else n_pass++;
        wait_done_a(n);
        n_total++; if ({n == 33, a_pass, a_err} !== {2'b11, 6'd0}) $display("FAIL mid_rerun got n=%0d pass=%b err=%0d want n=33 pass=1 err=0", n, a_pass, a_err); else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        a_mode = 0; b_mode = 0;
        a_rst = 1'b1; b_rst = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        test_reset();
        test_clean_sweep();
        test_single_fault();
        test_g_stuck();
        test_all_inverted();
        test_settle3();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
